// File: rtl/branch_pkg.sv
// Shared constants for the relative-branch path: FSM encoding,
// page geometry, target reset value and branch_op codes.
package branch_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADD_LO = 2'd1;
  localparam logic [1:0] ST_FIX_HI = 2'd2;

  localparam int PAGE_BITS = 8;

  localparam logic [15:0] TARGET_RST = 16'h0000;

  typedef enum logic [2:0] {
    BOP_BPL = 3'd0,
    BOP_BMI = 3'd1,
    BOP_BVC = 3'd2,
    BOP_BVS = 3'd3,
    BOP_BCC = 3'd4,
    BOP_BCS = 3'd5,
    BOP_BNE = 3'd6,
    BOP_BEQ = 3'd7
  } branch_op_e;

endpackage

// File: rtl/branch_target_page_adder.sv
// Low-byte add of PC and signed displacement, flagging when the
// result leaves the current page.
module page_adder
  import branch_pkg::*;
(
  input  logic [PAGE_BITS-1:0] i_pc_lo,
  input  logic [PAGE_BITS-1:0] i_off,
  output logic [PAGE_BITS-1:0] o_lo,
  output logic                 o_cross
);

  logic [PAGE_BITS:0] w_sum9;

  assign w_sum9  = {1'b0, i_pc_lo} + {1'b0, i_off};
  assign o_lo    = w_sum9[PAGE_BITS-1:0];
  // carry out means crossing only for positive offsets; the
  // opposite holds for negative ones
  assign o_cross = i_off[PAGE_BITS-1] ^ w_sum9[PAGE_BITS];

endmodule

// File: rtl/branch_target.sv
// 6502-style relative-branch target generator with page-cross fixup.
// Optional taken/cross counters under BRANCH_STATS_EN.
module branch_target
  import branch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic              offset_valid,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              busy,
  output logic              target_valid,
  output logic [ADDR_W-1:0] target,
  output logic              page_cross
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       cross_cnt
`endif
);

  localparam int HI_W = ADDR_W - PAGE_BITS;

  logic [1:0]           r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [OFF_W-1:0]     r_off;
  logic [PAGE_BITS-1:0] r_lo;
  logic                 r_dir;
  logic                 r_valid;
  logic                 r_pcross;
  logic [ADDR_W-1:0]    r_target;

  logic [PAGE_BITS-1:0] w_lo;
  logic                 w_cross;
  logic [HI_W-1:0]      w_pc_hi;
  logic [HI_W-1:0]      w_hi;
  logic                 w_start;

  page_adder u_add (
    .i_pc_lo (r_pc[PAGE_BITS-1:0]),
    .i_off   (r_off),
    .o_lo    (w_lo),
    .o_cross (w_cross)
  );

  assign w_start = branch_taken & offset_valid;
  assign w_pc_hi = r_pc[ADDR_W-1:PAGE_BITS];
  assign w_hi    = r_dir ? (w_pc_hi - HI_W'(1))
                         : (w_pc_hi + HI_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_off    <= '0;
      r_lo     <= '0;
      r_dir    <= 1'b0;
      r_valid  <= 1'b0;
      r_pcross <= 1'b0;
      r_target <= ADDR_W'(TARGET_RST);
    end else begin
      r_valid  <= 1'b0;
      r_pcross <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_pc    <= pc_in;
              r_off   <= offset;
              r_state <= ST_ADD_LO;
            end
          end
          ST_ADD_LO: begin
            if (w_cross) begin
              r_lo    <= w_lo;
              r_dir   <= r_off[OFF_W-1];
              r_state <= ST_FIX_HI;
            end else begin
              r_target <= {w_pc_hi, w_lo};
              r_valid  <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end
          ST_FIX_HI: begin
            r_target <= {w_hi, r_lo};
            r_valid  <= 1'b1;
            r_pcross <= 1'b1;
            r_state  <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign target_valid = r_valid;
  assign target       = r_target;
  assign page_cross   = r_pcross;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken;
  logic [15:0] r_xcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_taken <= '0;
      r_xcnt  <= '0;
    end else if (r_valid) begin
      if (r_taken != 16'hFFFF)
        r_taken <= r_taken + 16'd1;
      if (r_pcross && r_xcnt != 16'hFFFF)
        r_xcnt <= r_xcnt + 16'd1;
    end
  end

  assign taken_cnt = r_taken;
  assign cross_cnt = r_xcnt;
`endif

endmodule
